// File: rtl/pingpong_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_buffer_pkg : shared constants/helpers for the buffer      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pingpong_buffer_pkg;

  typedef logic [1:0] count_t;

  localparam logic c_slot_a = 1'b0;
  localparam logic c_slot_b = 1'b1;

  // Occupancy is derived purely from the two full flags.
  function automatic count_t occ_count(input logic [1:0] full);
    return count_t'({1'b0, full[0]}) + count_t'({1'b0, full[1]});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pingpong_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_buffer_if : producer/consumer handshake bundle            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pingpong_buffer_if #(
  parameter int N = 8
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );
endinterface
`default_nettype wire

// File: rtl/pingpong_buffer_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Nbit_2to1_Mux : N-bit 2:1 select, out = sel ? a : b                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module Nbit_2to1_Mux #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] a,
  input  wire logic [N-1:0] b,
  input  wire logic         sel,
  output logic      [N-1:0] out
);
  assign out = sel ? a : b;
endmodule
`default_nettype wire

// File: rtl/pingpong_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_buffer : two-slot ping-pong register buffer, valid/ready  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pingpong_buffer
  import pingpong_buffer_pkg::*;
#(
  parameter int N = 8
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          flush,
  pingpong_buffer_if.slave   bus
);

  logic [N-1:0] slot_q [2];
  logic [N-1:0] slot_d [2];
  logic [1:0]   full_q, full_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  logic         w_wr_en;
  logic         w_rd_en;
  logic [N-1:0] w_out_data;

  assign bus.in_ready  = ~full_q[wr_ptr_q];
  assign bus.out_valid = full_q[rd_ptr_q];
  assign bus.count     = occ_count(full_q);
  assign bus.out_data  = w_out_data;

  assign w_wr_en = bus.in_valid  & ~full_q[wr_ptr_q];
  assign w_rd_en = bus.out_ready &  full_q[rd_ptr_q];

  always_comb begin
    slot_d   = slot_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Occupancy-only clear; slot payloads are left as they are.
      full_d   = 2'b00;
      wr_ptr_d = c_slot_a;
      rd_ptr_d = c_slot_a;
    end else begin
      // With one word held, write and read address different slots.
      if (w_wr_en) begin
        slot_d[wr_ptr_q] = bus.in_data;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (w_rd_en) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      full_q    <= 2'b00;
      wr_ptr_q  <= c_slot_a;
      rd_ptr_q  <= c_slot_a;
    end else begin
      slot_q    <= slot_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  Nbit_2to1_Mux #(.N(N)) u_out_mux (
    .a   (slot_q[c_slot_b]),
    .b   (slot_q[c_slot_a]),
    .sel (rd_ptr_q),
    .out (w_out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pingpong_buffer : scoreboard bench for pingpong_buffer          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pingpong_buffer;

  localparam int N = 8;

  logic clk;
  logic reset_n;
  logic flush;

  pingpong_buffer_if #(.N(N)) bus ();

  pingpong_buffer #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side scoreboard: handshakes are stable mid-cycle, so sample at negedge.
  always @(negedge clk) begin
    if (reset_n && !flush && bus.out_valid && bus.out_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_underflow: got out_data=%0h with nothing expected", bus.out_data);
      end else begin
        logic [N-1:0] exp_v;
        exp_v = exp_q.pop_front();
        if (bus.out_data !== exp_v) begin
          failures = failures + 1;
          $display("FAIL scoreboard_data: got %0h expected %0h", bus.out_data, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    checks = checks + 1;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== 2'd0 || bus.out_data !== 8'h00) begin
      failures = failures + 1;
      $display("FAIL reset_state: ov=%b ir=%b cnt=%0d od=%0h required 0 1 0 00",
               bus.out_valid, bus.in_ready, bus.count, bus.out_data);
    end
    reset_n      = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.out_data !== 8'hA5) begin
      failures = failures + 1;
      $display("FAIL pre_reset_write: cnt=%0d od=%0h required 1 a5", bus.count, bus.out_data);
    end
    // Assert reset mid-cycle with a write pending.
    #2;
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    reset_n      = 1'b0;
    #1;
    checks = checks + 1;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== 2'd0 || bus.out_data !== 8'h00) begin
      failures = failures + 1;
      $display("FAIL async_reset: ov=%b ir=%b cnt=%0d od=%0h required 0 1 0 00",
               bus.out_valid, bus.in_ready, bus.count, bus.out_data);
    end
    step();
    checks = checks + 1;
    if (bus.count !== 2'd0 || bus.out_data !== 8'h00) begin
      failures = failures + 1;
      $display("FAIL reset_no_capture: cnt=%0d od=%0h required 0 00", bus.count, bus.out_data);
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    exp_q.delete();
    step();
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h11;
    bus.in_valid  = 1'b1;
    exp_q.push_back(8'h11);
    step();
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.out_data !== 8'h11 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL fill_one: cnt=%0d od=%0h ov=%b ir=%b required 1 11 1 1",
               bus.count, bus.out_data, bus.out_valid, bus.in_ready);
    end
    bus.in_data = 8'h22;
    exp_q.push_back(8'h22);
    step();
    checks = checks + 1;
    if (bus.count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 8'h11) begin
      failures = failures + 1;
      $display("FAIL fill_two: cnt=%0d ir=%b od=%0h required 2 0 11", bus.count, bus.in_ready, bus.out_data);
    end
    bus.in_data = 8'h33;
    step();
    bus.in_valid = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd2 || bus.out_data !== 8'h11) begin
      failures = failures + 1;
      $display("FAIL fill_ignore: cnt=%0d od=%0h required 2 11", bus.count, bus.out_data);
    end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    repeat (2) step();
    bus.out_ready = 1'b0;
    // Slot A still holds 0x11 and the read pointer is back on A.
    checks = checks + 1;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0 || bus.out_data !== 8'h11) begin
      failures = failures + 1;
      $display("FAIL drain_empty: ov=%b cnt=%0d od=%0h required 0 0 11", bus.out_valid, bus.count, bus.out_data);
    end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_data = 8'(i);
      exp_q.push_back(8'(i));
      step();
      checks = checks + 1;
      if (bus.count !== 2'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        failures = failures + 1;
        $display("FAIL stream_%0d: cnt=%0d ov=%b od=%0h required 1 1 %0h",
                 i, bus.count, bus.out_valid, bus.out_data, i);
      end
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd0 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL stream_end: cnt=%0d pending=%0d required 0 0", bus.count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77; exp_q.push_back(8'h77); step();
    bus.in_data   = 8'h88; exp_q.push_back(8'h88); step();
    bus.in_data   = 8'h44;
    bus.out_ready = 1'b1;
    checks = checks + 1;
    if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL full_backpressure: cnt=%0d ir=%b required 2 0", bus.count, bus.in_ready);
    end
    step();
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h88) begin
      failures = failures + 1;
      $display("FAIL full_read: cnt=%0d ir=%b od=%0h required 1 1 88", bus.count, bus.in_ready, bus.out_data);
    end
    exp_q.push_back(8'h44);
    step();
    bus.in_valid = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.out_data !== 8'h44) begin
      failures = failures + 1;
      $display("FAIL full_late_accept: cnt=%0d od=%0h required 1 44", bus.count, bus.out_data);
    end
    step();
    bus.out_ready = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL full_drained: cnt=%0d ov=%b required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    step();
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.out_data !== 8'h99) begin
      failures = failures + 1;
      $display("FAIL flush_setup: cnt=%0d od=%0h required 1 99", bus.count, bus.out_data);
    end
    flush         = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    // Pointers reset to A; slot A keeps 0x44 from the earlier test.
    checks = checks + 1;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h44) begin
      failures = failures + 1;
      $display("FAIL flush_clear: cnt=%0d ov=%b ir=%b od=%0h required 0 0 1 44",
               bus.count, bus.out_valid, bus.in_ready, bus.out_data);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h66;
    exp_q.push_back(8'h66);
    step();
    bus.in_valid  = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd1 || bus.out_data !== 8'h66 || bus.out_valid !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL flush_rewrite: cnt=%0d od=%0h ov=%b required 1 66 1", bus.count, bus.out_data, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks = checks + 1;
    if (bus.count !== 2'd0 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL flush_final: cnt=%0d pending=%0d required 0 0", bus.count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_back_to_back();
    test_flush();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
